pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage pipeline. Runs fetch, stalls and flushes, and drives operand forwarding.
//  Detects load-use hazards and redirects from the MEM stage (taken branch or jump), and steers EX operand forwarding.
//  Owns the run/drain/idle state derived from the top-level enable. Sits beside pc and the IF/ID, ID/EX, EX/MEM registers.
// PARAMETERS
//  REG_ADDR_W    5   register-file address width
//  DRAIN_CYCLES  4   cycles after fetch stop until ID..WB are empty
//  CNT_W         32  width of the performance counters
// PORTS
//  clk            in   1   clock; all state updates on the rising edge
//  rst            in   1   reset, synchronous, active-high
//  enable         in   1   1 = execute, 0 = stop fetching and drain
//  id_rs, id_rt   in   5   source registers of the instruction in ID
//  id_uses_rt     in   1   instruction in ID reads rt as a source (R-type, sw, beq)
//  ex_rs, ex_rt   in   5   source registers of the instruction in EX
//  ex_rd          in   5   destination register in EX
//  ex_mem_read    in   1   instruction in EX is a load
//  mem_rd         in   5   destination register in MEM
//  mem_reg_write  in   1   instruction in MEM writes the register file
//  wb_rd          in   5   destination register in WB
//  wb_reg_write   in   1   instruction in WB writes the register file
//  mem_redirect   in   1   (branch & zero) | jump, resolved in MEM
//  pc_write       out  1   pc may update this cycle
//  if_id_write    out  1   IF/ID register load enable
//  if_id_flush    out  1   IF/ID loads a NOP
//  id_ex_flush    out  1   ID/EX loads a bubble (all control bits 0)
//  ex_mem_flush   out  1   EX/MEM loads a bubble
//  fwd_a, fwd_b   out  2   00 = regfile, 01 = MEM alu_out, 10 = WB regfile_wdata
//  halted         out  1   pipeline idle and empty
//  perf_run, perf_stall, perf_flush  out  CNT_W  counters (see CONFIGURATION)
// BEHAVIOUR
//  FSM states: IDLE, RUN, DRAIN. Reset puts the FSM in IDLE, clears the drain counter and counters, and halted=1.
//  Output levels in IDLE: pc_write=0, if_id_write=0, id_ex_flush=1, flushes else 0.
//  Transitions:
//   IDLE -> RUN when enable=1. The first fetch happens in that same cycle (pc_write=1).
//   RUN -> DRAIN when enable=0. The drain counter is loaded with DRAIN_CYCLES-1.
//   DRAIN: pc_write=0, if_id_flush=1. Counter decrements each cycle; at 0 -> IDLE with halted=1 the next cycle.
//   DRAIN -> RUN if enable returns to 1 before the counter reaches 0. The counter is abandoned.
//  Load-use stall (RUN only, combinational):
//   condition: ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
//   response: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble; the load has left EX in the next cycle.
//  Redirect (any state except IDLE):
//   response: pc_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1. Three younger instructions are killed.
//   Redirect has priority over a load-use stall in the same cycle.
//   Redirect in DRAIN updates pc but does not restart fetch; the drain counter keeps counting.
//  Forwarding (combinational, all states):
//   EX/MEM beats MEM/WB. Register 0 is never forwarded.
//   fwd_a=01 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs; else 10 on the same test with wb_*; else 00.
//   fwd_b uses the same rules with ex_rt.
//  rst=1 mid-run: next cycle is IDLE with all outputs at reset values. In-flight instructions are not completed.
// CONFIGURATION
//  PIPE_HAZARD_CTRL_PERF_EN defined:
//   perf_run +1 per cycle in RUN.
//   perf_stall +1 per load-use stall cycle.
//   perf_flush +1 per redirect cycle.
//   All three saturate at 2^CNT_W-1 and clear on rst.
//  Not defined: the perf_* ports exist and are tied to 0, and no counter flops are built.
// STRUCTURE
//  Shared package cpu_pkg holds:
//   state typedef {IDLE, RUN, DRAIN}
//   FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
//  One sub-module, fwd_unit: purely combinational fwd_a/fwd_b, instantiated once.
// TESTING
//  1 rst, then enable=1: pc_write=1 from the first enabled cycle; halted=0 on the next cycle.
//  2 lw $2 in EX, add $3,$2,$4 in ID: exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1.
//  3 ex_rd=0 with ex_mem_read=1 and id_rs=0: no stall.
//  4 mem_redirect=1 together with a load-use condition: redirect outputs win (pc_write=1, three flushes), no stall.
//  5 mem_rd=wb_rd=5, both reg_write=1, ex_rs=5: fwd_a=01. With mem_reg_write=0: fwd_a=10.
//  6 Drop enable in RUN: pc_write=0 for 4 cycles, then halted=1.
//    Re-enable at drain cycle 2: RUN resumes and halted stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: sequencer states and forwarding-mux selects.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_MEM = 2'b01;  // operand from MEM-stage alu_out
    localparam logic [1:0] FWD_WB  = 2'b10;  // operand from WB-stage write data

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select. Purely combinational; EX/MEM beats MEM/WB
// and register 0 is never forwarded.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  w_we
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (m_we && (m_rd != '0) && (m_rd == src)) begin
            sel = FWD_MEM;
        end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Select source for each EX operand.
    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        fwd_b = fwd_sel(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: run/drain/idle FSM, load-use stall, MEM-stage
// redirect flushes and EX forwarding. Optional performance counters are built
// only when PIPE_HAZARD_CTRL_PERF_EN is defined; otherwise perf_* read as 0.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  mem_redirect,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  halted,
    output logic [CNT_W-1:0]      perf_run,
    output logic [CNT_W-1:0]      perf_stall,
    output logic [CNT_W-1:0]      perf_flush
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          load_use;
    logic          redirect_act;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign redirect_act = (state_q != IDLE) && mem_redirect;

    // Next state and drain countdown.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                // Reaching zero wins over a late re-enable.
                if (drain_cnt_q == '0) begin
                    state_d = IDLE;
                end else if (enable) begin
                    state_d = RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and drain counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Pipeline-register controls; redirect overrides everything else.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        case (state_q)
            IDLE: begin
                // First fetch happens in the cycle enable is seen.
                pc_write    = enable;
                if_id_write = enable;
                id_ex_flush = 1'b1;
            end
            RUN: begin
                pc_write    = !load_use;
                if_id_write = !load_use;
                id_ex_flush = load_use;
            end
            DRAIN: begin
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
            end
            default: begin
                id_ex_flush = 1'b1;
            end
        endcase
        if (redirect_act) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end
        halted = (state_q == IDLE);
    end

    fwd_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_fwd_unit (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_run_q, perf_run_d;
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
    logic             stall_cycle;

    assign stall_cycle = (state_q == RUN) && load_use && !mem_redirect;

    // Saturating event counters.
    always_comb begin
        perf_run_d   = perf_run_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if ((state_q == RUN) && (perf_run_q != '1)) perf_run_d = perf_run_q + CNT_W'(1);
        if (stall_cycle && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + CNT_W'(1);
        if (redirect_act && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + CNT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_run_q   <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_run_q   <= perf_run_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_run   = perf_run_q;
    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_run   = '0;
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule
